pwm_dma_arbiter: RTL and testbench
==================================

# pwm_dma_arbiter

Shares the single-transaction PWM audio DMA port among up to four requesters, for example the PWM sample fetcher, the descriptor loader and the CPU debug path. It sits between the requesters and the DMA bridge. Each requester's read or write becomes a one-cycle command pulse on the bridge. The arbiter waits for the bridge's completion pulse, then returns read data and a one-cycle ready to the granted requester. Only one transaction is outstanding at any time.

## Interface
- NUM_REQ, 2: number of requesters, range 2..4.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request, level, held until that requester's req_rdy.
- req_write  in  NUM_REQ  per-requester write request, level, held until req_rdy.
- req_addr  in  32*NUM_REQ  per-requester byte address; slice i is [32*i+31:32*i].
- req_writedata  in  32*NUM_REQ  per-requester write data, same slicing.
- req_readdata  out  32  read data for the requester currently pulsing req_rdy.
- req_rdy  out  NUM_REQ  one-hot, one-cycle completion pulse.
- dma_addr  out  32  bridge address.
- dma_read  out  1  bridge read command pulse.
- dma_write  out  1  bridge write command pulse.
- dma_writedata  out  32  bridge write data.
- dma_readdata  in  32  bridge read data, valid with dma_rdy.
- dma_rdy  in  1  bridge completion pulse.
- grant  out  2  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - The round-robin pointer is 0.
- The arbiter has four states: IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - A requester is active when its req_read or req_write is high.
  - If any requester is active, select the winner.
  - Latch the winner's index into grant.
  - Latch the winner's address, write data and operation.
  - Go to ISSUE.
  - If no requester is active, stay in IDLE.
- Operation select: if a requester has both req_read and req_write high, the read wins and the write is not performed.
- ISSUE:
  - Hold dma_addr and dma_writedata at the latched values.
  - Pulse dma_read or dma_write for exactly this one cycle.
  - Go to WAIT.
- WAIT:
  - Hold dma_read and dma_write low.
  - When dma_rdy is high, register dma_readdata into req_readdata and go to DONE.
  - For a write, req_readdata is registered as 0.
- DONE:
  - req_rdy[grant] is 1 for this one cycle.
  - Advance the round-robin pointer to (grant+1) mod NUM_REQ.
  - Go to IDLE.
- req_readdata holds its value until the next DONE.
- dma_addr and dma_writedata hold their latched values until the next grant.
- Requester rule: a requester must drop or replace its request at the clock edge where its req_rdy is high. A request still high in the following IDLE cycle is treated as a new transaction.
- A dma_rdy seen in IDLE, ISSUE or DONE is ignored.
- A request that changes while that requester is granted is ignored until the next IDLE.
- Asynchronous reset during any state forces IDLE immediately and clears all outputs and the pointer. The in-flight bridge transaction is abandoned; the bridge shares rst.

## Timing
- Edge 0: request sampled in IDLE.
- Cycle 1: ISSUE, with dma_read or dma_write high.
- Cycles 2..k: WAIT; dma_rdy arrives in cycle k.
- Cycle k+1: DONE, with req_rdy high.
- Arbitration overhead is 3 cycles beyond the bridge latency.
- The earliest next grant is sampled in the cycle after DONE.
- Every command pulse is exactly 1 cycle long.
- Exactly one req_rdy pulse is produced per issued command.

## Configuration
- Macro: PWM_DMA_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at the pointer and wraps at NUM_REQ.
  - With requester 3 last served and NUM_REQ=4, the search order is 0,1,2,3.
- Undefined: fixed priority; the lowest active index always wins.
  - The pointer register is omitted.
  - A continuously requesting low index may starve higher indices.

## Test plan
- Single read: requester 1 reads 0x0000_1000, bridge returns 0xCAFE_0001 two cycles after the pulse.
  - dma_read is high for 1 cycle with dma_addr 0x0000_1000.
  - req_rdy=2'b10 is high for 1 cycle with req_readdata 0xCAFE_0001.
- Single write: requester 0 writes 0x1234_5678 to 0x20.
  - dma_write pulses once with dma_addr 0x20 and dma_writedata 0x1234_5678.
  - req_rdy[0] pulses after dma_rdy; req_readdata is 0.
- Contention with RR defined: all four requesters hold reads.
  - Grants go in order 0,1,2,3,0.
  - There are no back-to-back command pulses without an intervening dma_rdy.
- Contention with RR undefined: requesters 0 and 2 hold requests continuously; only requester 0 is granted.
- Stray dma_rdy asserted in IDLE: no req_rdy pulse and no state change.
- Reset mid-transaction: rst pulses during WAIT.
  - busy, grant and req_rdy go to 0 asynchronously.
  - After reset release, a held request from requester 1 is issued fresh.

Source files
------------

// File: rtl/pwm_dma_arbiter.sv
// pwm_dma_arbiter: shares one single-transaction PWM audio DMA port among NUM_REQ requesters.
// Define PWM_DMA_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module pwm_dma_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_read,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [32*NUM_REQ-1:0] req_addr,
   input  logic [32*NUM_REQ-1:0] req_writedata,
   output logic [31:0]           req_readdata,
   output logic [NUM_REQ-1:0]    req_rdy,
   output logic [31:0]           dma_addr,
   output logic                  dma_read,
   output logic                  dma_write,
   output logic [31:0]           dma_writedata,
   input  logic [31:0]           dma_readdata,
   input  logic                  dma_rdy,
   output logic [1:0]            grant,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [NUM_REQ-1:0] active;
   logic [1:0] win, win_lo, win_hi;
   logic hi_ok, op_write, sel_write;
   logic [31:0] sel_addr, sel_wdata;
   int base;
   assign active = req_read | req_write;
`ifdef PWM_DMA_ARB_RR_EN
   logic [1:0] ptr;
   assign base = int'(ptr);
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (state == DONE) ptr <= (int'(grant) == NUM_REQ-1) ? 2'd0 : grant + 2'd1;
`else
   assign base = 0;
`endif
   // Lowest active index at or above base wins; if none, wrap to the lowest active index.
   always_comb begin
      win_lo = '0;
      win_hi = '0;
      hi_ok = 1'b0;
      sel_addr = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int k = NUM_REQ-1; k >= 0; k--)
         if (active[k]) begin
            win_lo = 2'(k);
            if (k >= base) begin
               win_hi = 2'(k);
               hi_ok = 1'b1;
            end
         end
      win = hi_ok ? win_hi : win_lo;
      for (int k = 0; k < NUM_REQ; k++)
         if (win == 2'(k)) begin
            sel_addr = req_addr[32*k +: 32];
            sel_wdata = req_writedata[32*k +: 32];
            sel_write = ~req_read[k];
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         dma_addr <= '0;
         dma_writedata <= '0;
         op_write <= 1'b0;
         req_readdata <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && |active) begin
            grant <= win;
            dma_addr <= sel_addr;
            dma_writedata <= sel_wdata;
            op_write <= sel_write;
         end
         if (state == WAIT && dma_rdy) req_readdata <= op_write ? '0 : dma_readdata;
      end
   always_comb begin
      state_nx = (state == IDLE)  ? (|active ? ISSUE : IDLE) :
                 (state == ISSUE) ? WAIT :
                 (state == WAIT)  ? (dma_rdy ? DONE : WAIT) : IDLE;
      dma_read = (state == ISSUE) && !op_write;
      dma_write = (state == ISSUE) && op_write;
      busy = (state != IDLE);
      for (int k = 0; k < NUM_REQ; k++) req_rdy[k] = (state == DONE) && (grant == 2'(k));
   end
endmodule

// File: tb/tb_pwm_dma_arbiter.sv
// tb_pwm_dma_arbiter: randomized bench with a transaction-level arbitration model and a bridge responder.
module tb_pwm_dma_arbiter;
   localparam int N = 4;
`ifdef PWM_DMA_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req_read = '0, req_write = '0, req_rdy;
   logic [32*N-1:0] req_addr = '0, req_writedata = '0;
   logic [31:0] req_readdata, dma_addr, dma_writedata;
   logic [31:0] dma_readdata = '0;
   logic dma_read, dma_write, busy;
   logic dma_rdy = 1'b0;
   logic [1:0] grant;
   int checks = 0, errs = 0;
   int lat = 2, pulses = 0, overlap = 0, cnt = 0, mptr = 0;
   bit pend = 0, stray = 0, last_write = 0;
   logic [31:0] bdata = '0, last_addr = '0, last_wdata = '0;
   bit rd[N], wr[N];
   logic [31:0] ad[N], wd[N];

   pwm_dma_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_writedata(req_writedata), .req_readdata(req_readdata),
      .req_rdy(req_rdy), .dma_addr(dma_addr), .dma_read(dma_read), .dma_write(dma_write),
      .dma_writedata(dma_writedata), .dma_readdata(dma_readdata), .dma_rdy(dma_rdy),
      .grant(grant), .busy(busy));

   always #5 clk = ~clk;

   // Bridge: records each command, answers lat cycles later with bdata; stray forces a dma_rdy.
   initial forever begin
      @(negedge clk);
      dma_rdy = 1'b0;
      if (rst) pend = 0;
      else begin
         if (dma_read || dma_write) begin
            pulses++;
            if (pend) overlap++;
            pend = 1;
            cnt = lat;
            last_addr = dma_addr;
            last_wdata = dma_writedata;
            last_write = dma_write;
         end else if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               pend = 0;
               dma_rdy = 1'b1;
               dma_readdata = bdata;
            end
         end
         if (stray) dma_rdy = 1'b1;
      end
   end

   function automatic int pick(input bit act[N], input int p);
      for (int k = 0; k < N; k++) if (act[(p+k)%N]) return (p+k)%N;
      return 0;
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         req_read[k] = rd[k];
         req_write[k] = wr[k];
         req_addr[32*k +: 32] = ad[k];
         req_writedata[32*k +: 32] = wd[k];
      end
   endtask

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         rd[k] = 0;
         wr[k] = 0;
         ad[k] = $urandom;
         wd[k] = $urandom;
      end
   endtask

   task automatic wait_rdy(output bit ok, output logic [N-1:0] r, output logic [31:0] d, output logic [1:0] g);
      ok = 0; r = '0; d = '0; g = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_rdy !== '0) begin
            ok = 1; r = req_rdy; d = req_readdata; g = grant;
            break;
         end
      end
   endtask

   task automatic test_reset();
      idle_all();
      drive();
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (grant !== 2'd0) begin errs++; $display("FAIL reset_grant got %0d want 0", grant); end
      checks++; if (req_rdy !== '0) begin errs++; $display("FAIL reset_rdy got %b want 0", req_rdy); end
      checks++; if ({dma_read, dma_write} !== 2'b00) begin errs++; $display("FAIL reset_cmd got %b want 00", {dma_read, dma_write}); end
      checks++; if ({dma_addr, dma_writedata, req_readdata} !== 96'd0) begin errs++; $display("FAIL reset_data got %h %h %h want 0", dma_addr, dma_writedata, req_readdata); end
      rst = 1'b0;
      mptr = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
   endtask

   task automatic test_contention();
      bit ok, act[N];
      logic [N-1:0] r, er;
      logic [31:0] d;
      logic [1:0] g;
      int w, o0;
      idle_all();
      for (int k = 0; k < N; k++) rd[k] = RR ? 1 : (k == 0 || k == 2);
      act = rd;
      o0 = overlap;
      drive();
      for (int t = 0; t < 5; t++) begin
         w = pick(act, mptr);
         bdata = $urandom;
         lat = $urandom_range(1, 4);
         wait_rdy(ok, r, d, g);
         er = '0; er[w] = 1'b1;
         checks++; if (!ok || g !== 2'(w)) begin errs++; $display("FAIL contention_grant[%0d] got %0d want %0d", t, g, w); end
         checks++; if (r !== er || d !== bdata) begin errs++; $display("FAIL contention_rdy[%0d] got %b/%h want %b/%h", t, r, d, er, bdata); end
         mptr = RR ? (w + 1) % N : 0;
      end
      idle_all();
      drive();
      checks++; if (overlap !== o0) begin errs++; $display("FAIL contention_overlap got %0d want %0d", overlap, o0); end
   endtask

   task automatic test_single_read();
      bit ok;
      logic [N-1:0] r;
      logic [31:0] d;
      logic [1:0] g;
      int p0;
      idle_all();
      rd[1] = 1; ad[1] = 32'h0000_1000;
      lat = 2; bdata = 32'hCAFE_0001; p0 = pulses;
      drive();
      wait_rdy(ok, r, d, g);
      rd[1] = 0;
      drive();
      checks++; if (!ok || r !== 4'b0010) begin errs++; $display("FAIL read_rdy got %b want 0010", r); end
      checks++; if (d !== 32'hCAFE_0001) begin errs++; $display("FAIL read_data got %h want cafe0001", d); end
      checks++; if (pulses - p0 !== 1 || last_write !== 0 || last_addr !== 32'h1000) begin errs++; $display("FAIL read_cmd got n=%0d w=%0b a=%h want n=1 w=0 a=00001000", pulses - p0, last_write, last_addr); end
      checks++; if (g !== 2'd1) begin errs++; $display("FAIL read_grant got %0d want 1", g); end
      mptr = RR ? 2 : 0;
      @(negedge clk);
      checks++; if (req_rdy !== '0 || busy !== 1'b0) begin errs++; $display("FAIL read_after got rdy=%b busy=%0b want 0 0", req_rdy, busy); end
   endtask

   task automatic test_single_write();
      bit ok;
      logic [N-1:0] r;
      logic [31:0] d;
      logic [1:0] g;
      int p0;
      idle_all();
      wr[0] = 1; ad[0] = 32'h20; wd[0] = 32'h1234_5678;
      lat = 3; bdata = 32'hDEAD_BEEF; p0 = pulses;
      drive();
      wait_rdy(ok, r, d, g);
      wr[0] = 0;
      drive();
      checks++; if (!ok || r !== 4'b0001) begin errs++; $display("FAIL write_rdy got %b want 0001", r); end
      checks++; if (d !== 32'd0) begin errs++; $display("FAIL write_data got %h want 0", d); end
      checks++; if (pulses - p0 !== 1 || last_write !== 1 || last_addr !== 32'h20 || last_wdata !== 32'h1234_5678) begin errs++; $display("FAIL write_cmd got n=%0d w=%0b a=%h d=%h want 1 1 00000020 12345678", pulses - p0, last_write, last_addr, last_wdata); end
      mptr = RR ? 1 : 0;
   endtask

   task automatic test_read_wins();
      bit ok;
      logic [N-1:0] r;
      logic [31:0] d;
      logic [1:0] g;
      idle_all();
      rd[3] = 1; wr[3] = 1;
      lat = 1; bdata = $urandom;
      drive();
      wait_rdy(ok, r, d, g);
      idle_all();
      drive();
      checks++; if (!ok || r !== 4'b1000 || last_write !== 0) begin errs++; $display("FAIL read_wins got rdy=%b w=%0b want 1000 0", r, last_write); end
      checks++; if (d !== bdata) begin errs++; $display("FAIL read_wins_data got %h want %h", d, bdata); end
      mptr = 0;
   endtask

   task automatic test_stray_rdy();
      logic [1:0] g0;
      logic [31:0] d0;
      idle_all();
      drive();
      @(negedge clk);
      g0 = grant; d0 = req_readdata;
      @(posedge clk); #1 stray = 1;
      @(posedge clk); #1 stray = 0;
      @(negedge clk);
      checks++; if (req_rdy !== '0 || busy !== 1'b0) begin errs++; $display("FAIL stray_rdy got rdy=%b busy=%0b want 0 0", req_rdy, busy); end
      @(negedge clk);
      checks++; if (grant !== g0 || req_readdata !== d0 || busy !== 1'b0) begin errs++; $display("FAIL stray_state got g=%0d d=%h want g=%0d d=%h", grant, req_readdata, g0, d0); end
   endtask

   task automatic test_random();
      bit ok, any, ewr, act[N];
      logic [N-1:0] r, er;
      logic [31:0] d, ead, ewd;
      logic [1:0] g;
      int w, p0;
      idle_all();
      for (int k = 0; k < N; k++) begin
         rd[k] = $urandom_range(0, 1);
         wr[k] = $urandom_range(0, 1);
      end
      for (int t = 0; t < 25; t++) begin
         any = 0;
         for (int k = 0; k < N; k++) any |= rd[k] | wr[k];
         if (!any) rd[$urandom_range(0, N-1)] = 1;
         drive();
         for (int k = 0; k < N; k++) act[k] = rd[k] | wr[k];
         w = pick(act, mptr);
         ewr = !rd[w]; ead = ad[w]; ewd = wd[w];
         lat = $urandom_range(1, 5); bdata = $urandom; p0 = pulses;
         wait_rdy(ok, r, d, g);
         er = '0; er[w] = 1'b1;
         checks++; if (!ok || g !== 2'(w) || r !== er) begin errs++; $display("FAIL random_grant[%0d] got g=%0d rdy=%b want g=%0d rdy=%b", t, g, r, w, er); end
         checks++; if (d !== (ewr ? 32'd0 : bdata)) begin errs++; $display("FAIL random_data[%0d] got %h want %h", t, d, ewr ? 32'd0 : bdata); end
         checks++; if (pulses - p0 !== 1 || last_write !== ewr || last_addr !== ead || (ewr && last_wdata !== ewd)) begin errs++; $display("FAIL random_cmd[%0d] got n=%0d w=%0b a=%h d=%h want 1 %0b %h %h", t, pulses - p0, last_write, last_addr, last_wdata, ewr, ead, ewd); end
         mptr = RR ? (w + 1) % N : 0;
         rd[w] = $urandom_range(0, 1); wr[w] = $urandom_range(0, 1);
         ad[w] = $urandom; wd[w] = $urandom;
         for (int k = 0; k < N; k++)
            if (k != w && !rd[k] && !wr[k] && $urandom_range(0, 2) == 0) begin
               rd[k] = $urandom_range(0, 1); wr[k] = !rd[k];
            end
      end
      idle_all();
      drive();
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [N-1:0] r;
      logic [31:0] d;
      logic [1:0] g;
      int p0;
      idle_all();
      rd[1] = 1; ad[1] = 32'h400;
      lat = 20; bdata = $urandom; p0 = pulses;
      drive();
      for (int i = 0; i < 10 && pulses == p0; i++) @(negedge clk);
      checks++; if (pulses == p0) begin errs++; $display("FAIL rstmid_issue got no command want 1"); end
      @(negedge clk);
      checks++; if (busy !== 1'b1 || grant !== 2'd1) begin errs++; $display("FAIL rstmid_wait got busy=%0b g=%0d want 1 1", busy, grant); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || grant !== 2'd0 || req_rdy !== '0) begin errs++; $display("FAIL rstmid_async got busy=%0b g=%0d rdy=%b want 0 0 0", busy, grant, req_rdy); end
      checks++; if (dma_addr !== 32'd0 || req_readdata !== 32'd0) begin errs++; $display("FAIL rstmid_clear got a=%h d=%h want 0 0", dma_addr, req_readdata); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mptr = 0;
      lat = 2; bdata = $urandom; p0 = pulses;
      wait_rdy(ok, r, d, g);
      idle_all();
      drive();
      checks++; if (!ok || g !== 2'd1 || r !== 4'b0010 || d !== bdata) begin errs++; $display("FAIL rstmid_fresh got g=%0d rdy=%b d=%h want 1 0010 %h", g, r, d, bdata); end
      checks++; if (pulses - p0 !== 1 || last_addr !== 32'h400) begin errs++; $display("FAIL rstmid_cmd got n=%0d a=%h want 1 00000400", pulses - p0, last_addr); end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_single_write();
      test_read_wins();
      test_stray_rdy();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end
endmodule
